// File: rtl/fifo_word_packer.sv
// Purpose: pops bytes from a registered-output byte FIFO and packs them little-endian into 32-bit words.
// Latency: 5 cycles from the first accepted pop to out_valid for a full word. A partial word is emitted on flush, or after FLUSH_TIMEOUT idle cycles.
// Backpressure: out_valid/out_ready handshake. While a word waits for out_ready, no pops are issued and the word is held stable.
// Ports:
//   clk, rst          - clock and asynchronous active-high reset
//   fifo_empty        - upstream FIFO empty flag
//   fifo_wr_en        - upstream FIFO write strobe; a write in the same cycle blocks the pop
//   fifo_rd_data      - FIFO read data, valid the cycle after an accepted pop
//   fifo_rd_en        - pop request
//   flush             - request to emit the partial word currently held
//   out_valid, out_ready, out_data, out_bytes - packed word output and its byte count (1..4)
module fifo_word_packer #(
    parameter int FLUSH_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic        fifo_wr_en,
    input  logic [7:0]  fifo_rd_data,
    output logic        fifo_rd_en,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_bytes
);

    typedef enum logic {FILL, EMIT} state_t;

    localparam logic [7:0] TIMEOUT = 8'(FLUSH_TIMEOUT);

    state_t      state;
    logic [2:0]  held;        // bytes already written into out_data
    logic        inflight;    // a popped byte arrives on fifo_rd_data this cycle
    logic [7:0]  timer;
    logic        flush_pend;

    logic in_fill;
    logic has_bytes;
    logic flush_now;
    logic timer_hit;
    logic emit_go;
    logic pop_ok;

    always_comb begin
        in_fill   = (state == FILL);
        has_bytes = (held != 3'd0);
        // A flush only matters if there is (or is about to be) something to emit.
        flush_now = in_fill & flush & (has_bytes | inflight);
        timer_hit = (timer >= TIMEOUT);
        emit_go   = in_fill & has_bytes & ~inflight & (timer_hit | flush_pend | flush_now);
        // Stop popping once an emit is decided, so no byte can land while in EMIT.
        fifo_rd_en = ~rst & in_fill & ~fifo_empty
                   & ((held + {2'b00, inflight}) < 3'd4)
                   & ~flush_pend & ~flush_now & ~emit_go;
        pop_ok    = fifo_rd_en & ~fifo_wr_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            held       <= 3'd0;
            inflight   <= 1'b0;
            timer      <= 8'd0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 32'd0;
            out_bytes  <= 3'd0;
        end else begin
            case (state)
                FILL: begin
                    inflight <= pop_ok;
                    if (inflight) begin
                        case (held[1:0])
                            2'd0:    out_data[7:0]   <= fifo_rd_data;
                            2'd1:    out_data[15:8]  <= fifo_rd_data;
                            2'd2:    out_data[23:16] <= fifo_rd_data;
                            default: out_data[31:24] <= fifo_rd_data;
                        endcase
                        held  <= held + 3'd1;
                        timer <= 8'd0;
                        if (held == 3'd3) begin
                            // Fourth byte completes the word: go straight to EMIT.
                            state      <= EMIT;
                            out_valid  <= 1'b1;
                            out_bytes  <= 3'd4;
                            flush_pend <= 1'b0;
                        end else if (flush) begin
                            // Honour the flush once this byte has landed.
                            flush_pend <= 1'b1;
                        end
                    end else if (emit_go) begin
                        state      <= EMIT;
                        out_valid  <= 1'b1;
                        out_bytes  <= held;
                        timer      <= 8'd0;
                        flush_pend <= 1'b0;
                    end else if (has_bytes && !pop_ok && !timer_hit) begin
                        timer <= timer + 8'd1;
                    end
                end
                default: begin
                    inflight <= 1'b0;
                    if (out_ready) begin
                        state     <= FILL;
                        held      <= 3'd0;
                        timer     <= 8'd0;
                        out_valid <= 1'b0;
                        out_data  <= 32'd0;
                        out_bytes <= 3'd0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
module tb_fifo_word_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty = 1'b1;
    logic        fifo_wr_en;
    logic [7:0]  fifo_rd_data = 8'd0;
    logic [7:0]  wr_byte;
    logic        fifo_rd_en;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;

    always #5 clk = ~clk;

    fifo_word_packer #(.FLUSH_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_wr_en(fifo_wr_en),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bytes(out_bytes)
    );

    typedef struct { logic [31:0] d; logic [2:0] n; } word_t;

    logic [7:0] fifo_q[$];
    logic [7:0] load_q[$];
    logic [7:0] exp_bytes[$];
    word_t      exp_words[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_words  = 0;
    bit  directed = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Upstream byte FIFO: registered read data, a write blocks the pop.
    always @(posedge clk) begin
        while (load_q.size() > 0) fifo_q.push_back(load_q.pop_front());
        if (fifo_rd_en && !fifo_wr_en && fifo_q.size() > 0)
            fifo_rd_data <= fifo_q.pop_front();
        if (fifo_wr_en) begin
            fifo_q.push_back(wr_byte);
            if (!directed) exp_bytes.push_back(wr_byte);
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
            check("rst_valid", {31'd0, out_valid}, 32'd0);
        end else if (out_valid) begin
            check("no_pop_in_emit", {31'd0, fifo_rd_en}, 32'd0);
            if (directed) begin
                if (exp_words.size() > 0) begin
                    check("word_data", out_data, exp_words[0].d);
                    check("word_bytes", {29'd0, out_bytes}, {29'd0, exp_words[0].n});
                end
                if (out_ready) begin
                    check("word_expected", {31'd0, exp_words.size() > 0}, 32'd1);
                    if (exp_words.size() > 0) void'(exp_words.pop_front());
                    n_words++;
                end
            end else begin
                int n;
                logic [31:0] e;
                n = int'(out_bytes);
                check("bytes_range", {31'd0, (n >= 1 && n <= 4)}, 32'd1);
                if (n >= 1 && n <= 4 && exp_bytes.size() >= n) begin
                    e = 32'd0;
                    for (int k = 0; k < n; k++) e = e | (32'(exp_bytes[k]) << (8 * k));
                    check("rand_data", out_data, e);
                    if (out_ready) begin
                        for (int k = 0; k < n; k++) void'(exp_bytes.pop_front());
                        n_words++;
                    end
                end else begin
                    check("rand_have_bytes", {31'd0, exp_bytes.size() >= n}, 32'd1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] b);
        load_q.push_back(b);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [2:0] n);
        word_t w;
        w.d = d;
        w.n = n;
        exp_words.push_back(w);
    endtask

    task automatic wait_words(input int target);
        for (int i = 0; i < 200; i++) begin
            if (n_words >= target) break;
            @(negedge clk);
        end
        check("word_count", n_words, target);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b1; fifo_wr_en = 1'b0; wr_byte = 8'd0; flush = 1'b0; out_ready = 1'b1;
        tick(); tick();
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_data", out_data, 32'd0);
        check("reset_bytes", {29'd0, out_bytes}, 32'd0);
        check("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        rst = 1'b0;
        tick();

        // Full word and first-pop latency.
        expect_word(32'h44332211, 3'd4);
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        k = 0;
        for (int i = 0; i < 10 && !fifo_rd_en; i++) @(negedge clk);
        for (int i = 0; i < 20 && !out_valid; i++) begin @(negedge clk); k++; end
        check("pop_to_valid_latency", k, 5);
        wait_words(1);

        // Stall: first word held stable, no pops during EMIT.
        tick();
        out_ready = 1'b0;
        expect_word(32'h04030201, 3'd4);
        expect_word(32'h08070605, 3'd4);
        for (int b = 1; b <= 8; b++) load(8'(b));
        repeat (10) tick();
        check("stalled_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        wait_words(3);

        // Idle timeout on a single byte.
        tick();
        expect_word(32'h000000A5, 3'd1);
        load(8'hA5);
        k = 0;
        for (int i = 0; i < 40 && !out_valid; i++) begin @(negedge clk); k++; end
        check("timeout_latency", k, 13);
        wait_words(4);

        // Flush while the second byte is inflight.
        tick();
        expect_word(32'h0000EFBE, 3'd2);
        load(8'hBE); load(8'hEF);
        tick(); tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk); @(negedge clk);
        check("flush_valid", {31'd0, out_valid}, 32'd1);
        wait_words(5);

        // Write collides with a pop request.
        tick();
        expect_word(32'hC4C3C2C1, 3'd4);
        load(8'hC1); load(8'hC2); load(8'hC3);
        tick();
        fifo_wr_en = 1'b1; wr_byte = 8'hC4;
        tick();
        fifo_wr_en = 1'b0;
        wait_words(6);

        // Reset with three bytes held.
        tick();
        load(8'hD1); load(8'hD2); load(8'hD3);
        repeat (6) tick();
        #2 rst = 1'b1;
        #1;
        check("rst_held_valid", {31'd0, out_valid}, 32'd0);
        check("rst_held_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("rst_held_data", out_data, 32'd0);
        tick();
        rst = 1'b0;
        expect_word(32'h8D7C6B5A, 3'd4);
        load(8'h5A); load(8'h6B); load(8'h7C); load(8'h8D);
        wait_words(7);

        // Reset while a word waits in EMIT.
        tick();
        out_ready = 1'b0;
        load(8'hE1); load(8'hE2); load(8'hE3); load(8'hE4);
        repeat (8) tick();
        check("emit_before_rst", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_emit_valid", {31'd0, out_valid}, 32'd0);
        check("rst_emit_bytes", {29'd0, out_bytes}, 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        expect_word(32'h00000077, 3'd1);
        load(8'h77);
        wait_words(8);
        check("directed_words_left", exp_words.size(), 0);

        // Randomised traffic against the byte-stream model.
        tick();
        directed = 1'b0;
        for (int i = 0; i < 800; i++) begin
            fifo_wr_en = ($urandom_range(99) < 40);
            wr_byte    = 8'($urandom);
            flush      = ($urandom_range(99) < 4);
            out_ready  = ($urandom_range(99) < 70);
            tick();
        end
        fifo_wr_en = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (exp_bytes.size() == 0 && !out_valid) break;
            tick();
        end
        check("random_drain", exp_bytes.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
